// File: rtl/pluto_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pluto_spi_pkg                                                            |
// | Shared types, frame layout and field constants for the SPI frame engine. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pluto_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Word positions relative to N_AXES (velocity words occupy 0..N_AXES-1)
  localparam int c_dout_word_ofs = 0;
  localparam int c_cfg_word_ofs  = 1;

  localparam int c_wdt_bit       = 31;
  localparam int c_dirtime_lsb   = 0;
  localparam int c_spol_bit      = 7;
  localparam int c_steptime_lsb  = 8;
  localparam int c_tap_lsb       = 14;

  function automatic int frame_bytes(input int n_axes);
    return 4 * (n_axes + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pluto_spi_frame_engine_spi_byte_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_byte_shifter                                                         |
// | Pin synchronisers, SPI mode edge selection, bit counter, 8-bit shifters. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_byte_shifter #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ssel,
  input  logic       mosi,
  input  logic [7:0] tx_byte,
  output logic       miso,
  output logic       ssel_fall,
  output logic       ssel_rise,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       partial
);

  localparam bit c_sample_on_rise = (CPOL == CPHA);

  // [0] metastable, [1] synchronised, [2] edge-detect delay
  logic [2:0] r_sck_sr;
  logic [2:0] r_ssel_sr;
  logic [1:0] r_mosi_sr;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic       r_rx_valid;

  logic w_sck_rise, w_sck_fall, w_sample, w_shift, w_active;

  assign w_sck_rise = r_sck_sr[1] & ~r_sck_sr[2];
  assign w_sck_fall = ~r_sck_sr[1] & r_sck_sr[2];
  assign w_sample   = c_sample_on_rise ? w_sck_rise : w_sck_fall;
  assign w_shift    = c_sample_on_rise ? w_sck_fall : w_sck_rise;
  assign w_active   = ~r_ssel_sr[1];

  assign ssel_fall  = r_ssel_sr[2] & ~r_ssel_sr[1];
  assign ssel_rise  = ~r_ssel_sr[2] & r_ssel_sr[1];

  // SCK chain resets to its idle level so reset release never fakes an edge;
  // SSEL chain resets low so a frame already in progress never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sr   <= {3{CPOL}};
      r_ssel_sr  <= '0;
      r_mosi_sr  <= '0;
      r_bit_cnt  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_sck_sr   <= {r_sck_sr[1:0], sck};
      r_ssel_sr  <= {r_ssel_sr[1:0], ssel};
      r_mosi_sr  <= {r_mosi_sr[0], mosi};
      r_rx_valid <= 1'b0;
      if (ssel_fall) begin
        r_bit_cnt <= '0;
        r_tx_sr   <= tx_byte;
      end else if (w_active && w_sample) begin
        r_rx_sr    <= {r_rx_sr[6:0], r_mosi_sr[1]};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_valid <= (r_bit_cnt == 3'd7);
      end else if (w_active && w_shift) begin
        // A shift edge at a byte boundary presents the next byte's MSB
        r_tx_sr <= (r_bit_cnt == 3'd0) ? tx_byte : {r_tx_sr[6:0], 1'b0};
      end
    end
  end

  assign miso     = r_tx_sr[7];
  assign rx_valid = r_rx_valid;
  assign rx_byte  = r_rx_sr;
  assign partial  = (r_bit_cnt != 3'd0);

endmodule
`default_nettype wire

// File: rtl/pluto_spi_frame_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pluto_spi_frame_engine                                                   |
// | SPI frame engine: atomic position readback, shadowed command commit.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pluto_spi_frame_engine
  import pluto_spi_pkg::*;
#(
  parameter int N_AXES = 4,
  parameter int POS_W  = 21,
  parameter int VEL_W  = 12,
  parameter int DOUT_W = 14,
  parameter int DIN_W  = 16,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic                      clk,
  input  logic                      nRESET,
  input  logic                      SCK,
  input  logic                      SSEL,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic [N_AXES*POS_W-1:0]   pos_flat,
  input  logic [DIN_W-1:0]          din,
  output logic [N_AXES*VEL_W-1:0]   vel_flat,
  output logic [DOUT_W-1:0]         dout,
  output logic [3:0]                dirtime,
  output logic [3:0]                steptime,
  output logic [1:0]                tap,
  output logic                      spolarity,
  output logic                      commit,
  output logic                      frame_err,
  output logic                      wdt_kick
);

  localparam int c_fb        = frame_bytes(N_AXES);
  localparam int c_cnt_w     = $clog2(c_fb + 2);
  localparam int c_dout_word = N_AXES + c_dout_word_ofs;
  localparam int c_cfg_word  = N_AXES + c_cfg_word_ofs;
  localparam logic [c_cnt_w-1:0] c_fb_cnt  = c_cnt_w'(c_fb);
  localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(c_fb + 1);

  state_t                    r_state, w_state_next;
  logic [c_cnt_w-1:0]        r_byte_cnt;
  logic [N_AXES*POS_W-1:0]   r_pos_snap;
  logic [DIN_W-1:0]          r_din_snap;
  logic [c_fb*8-1:0]         r_shadow;
  logic [N_AXES*VEL_W-1:0]   r_vel;
  logic [DOUT_W-1:0]         r_dout;
  logic [3:0]                r_dirtime, r_steptime;
  logic [1:0]                r_tap;
  logic                      r_spolarity, r_commit, r_frame_err, r_wdt_kick;

  logic [c_fb*8-1:0]         w_miso_frame, w_frame_shifted;
  logic [7:0]                w_tx_byte, w_rx_byte;
  logic                      w_ssel_fall, w_ssel_rise, w_rx_valid, w_partial, w_frame_ok;
  logic                      w_unused_shadow;

  spi_byte_shifter #(.CPOL(CPOL), .CPHA(CPHA)) u_shifter (
    .clk       (clk),
    .rst_n     (nRESET),
    .sck       (SCK),
    .ssel      (SSEL),
    .mosi      (MOSI),
    .tx_byte   (w_tx_byte),
    .miso      (MISO),
    .ssel_fall (w_ssel_fall),
    .ssel_rise (w_ssel_rise),
    .rx_valid  (w_rx_valid),
    .rx_byte   (w_rx_byte),
    .partial   (w_partial)
  );

  for (genvar k = 0; k < N_AXES; k++) begin : g_pos_word
    assign w_miso_frame[k*32 +: 32] =
      {{(32-POS_W){r_pos_snap[k*POS_W+POS_W-1]}}, r_pos_snap[k*POS_W +: POS_W]};
  end
  assign w_miso_frame[c_dout_word*32 +: 32] = 32'(r_din_snap);
  assign w_miso_frame[c_cfg_word*32 +: 32]  = '0;

  // Counts at or past the frame end shift everything out, giving 0x00 bytes
  assign w_frame_shifted = w_miso_frame >> {r_byte_cnt, 3'b000};
  // Byte 0 comes from the live positions since the snapshot lands this same edge
  assign w_tx_byte  = w_ssel_fall ? pos_flat[7:0] : w_frame_shifted[7:0];
  assign w_frame_ok = (r_byte_cnt == c_fb_cnt) && !w_partial;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_ssel_fall) w_state_next = SHIFT;
      SHIFT:   if (w_ssel_rise) w_state_next = DONE;
      DONE:    w_state_next = w_ssel_fall ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state     <= IDLE;
      r_byte_cnt  <= '0;
      r_pos_snap  <= '0;
      r_din_snap  <= '0;
      r_shadow    <= '0;
      r_vel       <= '0;
      r_dout      <= '0;
      r_dirtime   <= '0;
      r_steptime  <= '0;
      r_tap       <= '0;
      r_spolarity <= 1'b0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wdt_kick  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      r_wdt_kick  <= 1'b0;
      if (w_ssel_fall) begin
        r_pos_snap <= pos_flat;
        r_din_snap <= din;
        r_byte_cnt <= '0;
      end else if (r_state == SHIFT && w_rx_valid) begin
        for (int b = 0; b < c_fb; b++) begin
          if (r_byte_cnt == c_cnt_w'(b)) r_shadow[b*8 +: 8] <= w_rx_byte;
        end
        if (r_byte_cnt != c_cnt_sat) r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (r_state == DONE) begin
        if (w_frame_ok) begin
          for (int k = 0; k < N_AXES; k++) begin
            r_vel[k*VEL_W +: VEL_W] <= r_shadow[k*32 +: VEL_W];
          end
          r_dout      <= r_shadow[c_dout_word*32 +: DOUT_W];
          r_dirtime   <= r_shadow[c_cfg_word*32 + c_dirtime_lsb +: 4];
          r_steptime  <= r_shadow[c_cfg_word*32 + c_steptime_lsb +: 4];
          r_tap       <= r_shadow[c_cfg_word*32 + c_tap_lsb +: 2];
          r_spolarity <= r_shadow[c_cfg_word*32 + c_spol_bit];
          r_commit    <= 1'b1;
          r_wdt_kick  <= r_shadow[c_dout_word*32 + c_wdt_bit];
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // Reserved shadow bits are received but carry no function
  assign w_unused_shadow = ^r_shadow;

  assign vel_flat  = r_vel;
  assign dout      = r_dout;
  assign dirtime   = r_dirtime;
  assign steptime  = r_steptime;
  assign tap       = r_tap;
  assign spolarity = r_spolarity;
  assign commit    = r_commit;
  assign frame_err = r_frame_err;
  assign wdt_kick  = r_wdt_kick;

endmodule
`default_nettype wire

// File: tb/tb_pluto_spi_frame_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pluto_spi_frame_engine                                                |
// | Self-checking bench: mode 0 and mode 3 instances driven in lockstep.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pluto_spi_frame_engine;

  localparam int NA = 4, PW = 21, VW = 12, DOW = 14, DIW = 16, FB = 24;

  logic clk = 1'b0, nRESET = 1'b0, sck0 = 1'b0, sck3 = 1'b1, ssel = 1'b1, mosi = 1'b0;
  logic [NA*PW-1:0] pos_flat = '0;
  logic [DIW-1:0]   din = '0;

  logic             miso0, miso3;
  logic [NA*VW-1:0] vel0, vel3;
  logic [DOW-1:0]   dout0, dout3;
  logic [3:0]       dir0, dir3, step0, step3;
  logic [1:0]       tap0, tap3;
  logic             spol0, spol3, commit0, commit3, err0, err3, wdt0, wdt3;

  pluto_spi_frame_engine #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .nRESET(nRESET), .SCK(sck0), .SSEL(ssel), .MOSI(mosi), .MISO(miso0),
    .pos_flat(pos_flat), .din(din), .vel_flat(vel0), .dout(dout0), .dirtime(dir0),
    .steptime(step0), .tap(tap0), .spolarity(spol0), .commit(commit0),
    .frame_err(err0), .wdt_kick(wdt0));

  pluto_spi_frame_engine #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .nRESET(nRESET), .SCK(sck3), .SSEL(ssel), .MOSI(mosi), .MISO(miso3),
    .pos_flat(pos_flat), .din(din), .vel_flat(vel3), .dout(dout3), .dirtime(dir3),
    .steptime(step3), .tap(tap3), .spolarity(spol3), .commit(commit3),
    .frame_err(err3), .wdt_kick(wdt3));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, rise_cyc = 0, cyc = 0;
  int n_commit[2] = '{default: 0};
  int n_err[2] = '{default: 0};
  int n_wdt[2] = '{default: 0};
  int n_wdt_alone[2] = '{default: 0};
  int last_commit_cyc[2] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (commit0) begin n_commit[0] <= n_commit[0] + 1; last_commit_cyc[0] <= cyc; end
    if (commit3) begin n_commit[1] <= n_commit[1] + 1; last_commit_cyc[1] <= cyc; end
    if (err0) n_err[0] <= n_err[0] + 1;
    if (err3) n_err[1] <= n_err[1] + 1;
    if (wdt0) n_wdt[0] <= n_wdt[0] + 1;
    if (wdt3) n_wdt[1] <= n_wdt[1] + 1;
    if (wdt0 && !commit0) n_wdt_alone[0] <= n_wdt_alone[0] + 1;
    if (wdt3 && !commit3) n_wdt_alone[1] <= n_wdt_alone[1] + 1;
  end

  // Reference model state
  logic [7:0]     tx[32];
  logic [7:0]     rx[2][32];
  logic [PW-1:0]  m_snap[NA];
  logic [DIW-1:0] m_din_snap;
  int unsigned    m_vel[NA];
  int unsigned    m_dout, m_dir, m_step, m_tap, m_spol;
  int             m_commits = 0, m_errs = 0, m_wdts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tx_word(input int w);
    return {tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]};
  endfunction

  function automatic logic [31:0] rx_word(input int d, input int w);
    return {rx[d][4*w+3], rx[d][4*w+2], rx[d][4*w+1], rx[d][4*w]};
  endfunction

  // Positions are two's complement in PW bits; returned sign-extended to 32
  function automatic logic [31:0] exp_word(input int w);
    longint p;
    if (w < NA) begin
      p = longint'(m_snap[w]);
      if (p >= (longint'(1) << (PW - 1))) p = p - (longint'(1) << PW);
      return 32'(p);
    end
    if (w == NA) return 32'(m_din_snap);
    return 32'h0;
  endfunction

  task automatic fill_tx();
    for (int b = 0; b < 32; b++) tx[b] = 8'($urandom);
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NA; k++) pos_flat[k*PW +: PW] = PW'($urandom);
    din = DIW'($urandom);
  endtask

  task automatic take_snapshot();
    for (int k = 0; k < NA; k++) m_snap[k] = pos_flat[k*PW +: PW];
    m_din_snap = din;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NA; k++) m_vel[k] = 0;
    m_dout = 0; m_dir = 0; m_step = 0; m_tap = 0; m_spol = 0;
  endtask

  task automatic model_apply(input int nbytes, input int xbits);
    logic [31:0] cfg;
    if (nbytes == FB && xbits == 0) begin
      for (int k = 0; k < NA; k++) m_vel[k] = tx_word(k) % (1 << VW);
      m_dout = tx_word(NA) % (1 << DOW);
      if (tx_word(NA) >= 32'h8000_0000) m_wdts++;
      cfg    = tx_word(NA + 1);
      m_dir  = cfg % 16;
      m_spol = (cfg / 128) % 2;
      m_step = (cfg / 256) % 16;
      m_tap  = (cfg / 16384) % 4;
      m_commits++;
    end else begin
      m_errs++;
    end
  endtask

  // Master drives both modes at once: mode 3 shifts on sck3 fall, both sample on rise
  task automatic spi_frame(input int nbytes, input int xbits, input int rst_byte, input bit pos_chg);
    int lim;
    ssel = 1'b0;
    wait_clk(6);
    if (pos_chg) pos_flat[0 +: PW] = 21'h000200;
    for (int b = 0; b < nbytes + ((xbits > 0) ? 1 : 0); b++) begin
      if (b == rst_byte) begin
        nRESET = 1'b0; wait_clk(3); nRESET = 1'b1; wait_clk(1);
      end
      lim = (b == nbytes) ? 8 - xbits : 0;
      for (int i = 7; i >= lim; i--) begin
        sck3 = 1'b0;
        mosi = tx[b][i];
        wait_clk(4);
        rx[0][b][i] = miso0;
        rx[1][b][i] = miso3;
        sck0 = 1'b1; sck3 = 1'b1;
        wait_clk(4);
        sck0 = 1'b0;
        wait_clk(4);
      end
    end
    wait_clk(2);
    ssel = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic check_outputs(input string tag);
    logic [NA*VW-1:0] ev;
    logic [10:0] ecfg;
    for (int k = 0; k < NA; k++) ev[k*VW +: VW] = VW'(m_vel[k]);
    ecfg = {4'(m_dir), 4'(m_step), 2'(m_tap), 1'(m_spol)};
    check({tag, "/vel0"}, vel0, ev);
    check({tag, "/vel3"}, vel3, ev);
    check({tag, "/dout0"}, dout0, DOW'(m_dout));
    check({tag, "/dout3"}, dout3, DOW'(m_dout));
    check({tag, "/cfg0"}, {dir0, step0, tap0, spol0}, ecfg);
    check({tag, "/cfg3"}, {dir3, step3, tap3, spol3}, ecfg);
    check({tag, "/commits0"}, n_commit[0], m_commits);
    check({tag, "/commits3"}, n_commit[1], m_commits);
    check({tag, "/errs0"}, n_err[0], m_errs);
    check({tag, "/errs3"}, n_err[1], m_errs);
    check({tag, "/wdt0"}, n_wdt[0], m_wdts);
    check({tag, "/wdt3"}, n_wdt[1], m_wdts);
    check({tag, "/wdt_alone"}, n_wdt_alone[0] + n_wdt_alone[1], 0);
  endtask

  task automatic check_miso(input int nbytes, input string tag);
    for (int w = 0; w < nbytes / 4; w++) begin
      check({tag, "/miso0"}, rx_word(0, w), exp_word(w));
      check({tag, "/miso3"}, rx_word(1, w), exp_word(w));
    end
  endtask

  task automatic check_latency(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "/commit_latency"},
            64'((last_commit_cyc[d] - rise_cyc >= 1) && (last_commit_cyc[d] - rise_cyc <= 4)), 64'd1);
    end
  endtask

  task automatic run_frame(input int nbytes, input int xbits, input bit pos_chg, input string tag);
    take_snapshot();
    spi_frame(nbytes, xbits, -1, pos_chg);
    wait_clk(10);
    model_apply(nbytes, xbits);
    check_miso(nbytes, tag);
    check_outputs(tag);
    if (nbytes == FB && xbits == 0) check_latency(tag);
  endtask

  initial begin
    int lens[5];
    lens = '{24, 17, 24, 28, 24};
    model_reset();

    // Reset state
    randomize_inputs();
    wait_clk(3);
    check("reset/miso", {miso0, miso3}, 2'b00);
    check("reset/pulses", {commit0, err0, wdt0, commit3, err3, wdt3}, 6'b0);
    check_outputs("reset");
    nRESET = 1'b1;
    wait_clk(3);

    // Full frame, word0 = 0x00000123
    fill_tx();
    {tx[3], tx[2], tx[1], tx[0]} = 32'h0000_0123;
    run_frame(24, 0, 1'b0, "full");
    check("full/vel0_123", vel0[11:0], 12'h123);
    check("full/vel3_123", vel3[11:0], 12'h123);

    // Snapshot atomicity and sign extension
    pos_flat[0 +: PW]  = 21'h000100;
    pos_flat[PW +: PW] = 21'h1FFFFF;
    fill_tx();
    run_frame(24, 0, 1'b1, "snap");
    check("snap/pos0_bytes", rx_word(0, 0), 32'h0000_0100);
    check("snap/pos1_bytes", rx_word(0, 1), 32'hFFFF_FFFF);

    // Watchdog kick with dout
    fill_tx();
    {tx[19], tx[18], tx[17], tx[16]} = 32'h8000_2ABC;
    run_frame(24, 0, 1'b0, "wdt");
    check("wdt/dout", dout0, 14'h2ABC);

    // Short, over-length and partial-byte frames are rejected
    fill_tx();
    run_frame(10, 0, 1'b0, "short");
    fill_tx();
    run_frame(28, 0, 1'b0, "long");
    check("long/tail_zero", rx_word(0, 6), 32'h0);
    fill_tx();
    run_frame(24, 3, 1'b0, "partial");

    // Randomised frames
    for (int i = 0; i < 5; i++) begin
      randomize_inputs();
      fill_tx();
      run_frame(lens[i], 0, 1'b0, "rand");
    end

    // Back-to-back frames: second SSEL fall lands while the first is in DONE
    randomize_inputs();
    fill_tx();
    take_snapshot();
    spi_frame(24, 0, -1, 1'b0);
    model_apply(24, 0);
    fill_tx();
    randomize_inputs();
    wait_clk(1);
    take_snapshot();
    spi_frame(24, 0, -1, 1'b0);
    wait_clk(10);
    model_apply(24, 0);
    check_miso(24, "b2b");
    check_outputs("b2b");
    check_latency("b2b");

    // Reset at byte 7 aborts the frame silently
    fill_tx();
    take_snapshot();
    spi_frame(24, 0, 7, 1'b0);
    wait_clk(10);
    model_reset();
    check_outputs("midreset");
    fill_tx();
    randomize_inputs();
    run_frame(24, 0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
